// File: rtl/rv_fetch_pkg.sv
// Shared fetch-stage definitions: architectural widths, bubble encoding and FSM states.
package rv_fetch_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    // addi x0,x0,0 -- the canonical RISC-V no-op used as a pipeline bubble
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: loads a fetched instruction, inserts a bubble, or holds.
module ifid_reg
    import rv_fetch_pkg::*;
#(
    parameter logic [ILEN-1:0] NOP_INSTR = rv_fetch_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            bubble,
    input  logic [XLEN-1:0] pc_d,
    input  logic [ILEN-1:0] instr_d,
    output logic [XLEN-1:0] ifid_pc,
    output logic [ILEN-1:0] ifid_instr,
    output logic            ifid_valid
);

    // Bubble wins over load; ifid_pc keeps its last value under a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_pc    <= '0;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end else if (bubble) begin
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end else if (load) begin
            ifid_pc    <= pc_d;
            ifid_instr <= instr_d;
            ifid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: PC register, redirect/stall/flush sequencing and a sticky error halt.
module pc_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int unsigned     MEM_WORDS = 151,
    parameter logic [ILEN-1:0] NOP_INSTR = rv_fetch_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] pc_out,
    input  logic [ILEN-1:0] instr_in,
    output logic [XLEN-1:0] ifid_pc,
    output logic [ILEN-1:0] ifid_instr,
    output logic            ifid_valid,
    output logic            halted,
    output logic            err_misaligned,
    output logic            err_range
);

    // Full-width byte limit so a huge PC can never alias into the memory
    localparam logic [XLEN-1:0] FETCH_LIMIT = XLEN'(MEM_WORDS) * XLEN'(4);

    fetch_state_e    state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic            mis_q, mis_n;
    logic            rng_q, rng_n;
    logic            load, bubble;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH_RUN;
            pc    <= RESET_PC;
            mis_q <= 1'b0;
            rng_q <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            mis_q <= mis_n;
            rng_q <= rng_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        mis_n   = mis_q;
        rng_n   = rng_q;
        load    = 1'b0;
        bubble  = 1'b0;
        case (state)
            FETCH_RUN: begin
                if (redirect && (redirect_target[1:0] != 2'b00)) begin
                    state_n = FETCH_HALT;
                    mis_n   = 1'b1;
                    bubble  = 1'b1;
                end else if (redirect) begin
                    pc_n   = redirect_target;
                    bubble = 1'b1;
                end else if (pc >= FETCH_LIMIT) begin
                    state_n = FETCH_HALT;
                    rng_n   = 1'b1;
                    bubble  = 1'b1;
                end else if (stall) begin
                    // A flush during a stall still kills the held slot
                    bubble = flush;
                end else if (flush) begin
                    pc_n   = pc + XLEN'(4);
                    bubble = 1'b1;
                end else begin
                    pc_n = pc + XLEN'(4);
                    load = 1'b1;
                end
            end
            FETCH_HALT: begin
                bubble = 1'b1;
            end
            default: begin
                state_n = FETCH_HALT;
                bubble  = 1'b1;
            end
        endcase
    end

    ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .bubble     (bubble),
        .pc_d       (pc),
        .instr_d    (instr_in),
        .ifid_pc    (ifid_pc),
        .ifid_instr (ifid_instr),
        .ifid_valid (ifid_valid)
    );

    assign pc_out         = pc;
    assign halted         = (state == FETCH_HALT);
    assign err_misaligned = mis_q;
    assign err_range      = rng_q;

endmodule
